// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - TileLink UH opcode constants and memory responder helpers
package tl_pkg;

    // A channel opcodes
    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    // D channel opcodes
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // Largest legal transfer sizes (log2 bytes)
    localparam logic [3:0] TL_GET_MAX_SIZE = 4'd7;
    localparam logic [3:0] TL_PUT_MAX_SIZE = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2
    } resp_state_e;

    // True when addr is a multiple of 2^size bytes
    function automatic logic is_aligned(input logic [31:0] addr, input logic [3:0] size);
        logic [31:0] low_mask;
        low_mask = (32'd1 << size) - 32'd1;
        return (addr & low_mask) == 32'd0;
    endfunction

    // Index of the final beat of a Get burst: max(1, 2^size/4) - 1
    function automatic logic [4:0] last_beat(input logic [3:0] size);
        logic [5:0] n_beats;
        if (size <= 4'd2) begin
            n_beats = 6'd1;
        end else begin
            n_beats = 6'd1 << (size - 4'd2);
        end
        return 5'(n_beats - 6'd1);
    endfunction

endpackage

// File: rtl/tl_mem_array.sv
// rtl/tl_mem_array.sv - 32-bit word RAM, one byte-enabled write port, one registered read port
module tl_mem_array #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_be_i,
    input  logic [31:0]       wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rd_data_q;

    // Storage is deliberately not reset; read data lags the address by one cycle
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
        rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink UH memory slave answering Get bursts and Put writes
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14,
    parameter int RS         = 1
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_resetn_i,

    input  logic [2:0]    tl_a_opcode,
    input  logic [2:0]    tl_a_param,
    input  logic [3:0]    tl_a_size,
    input  logic [RS-1:0] tl_a_source,
    input  logic [31:0]   tl_a_address,
    input  logic [3:0]    tl_a_mask,
    input  logic [31:0]   tl_a_data,
    input  logic          tl_a_corrupt,
    input  logic          tl_a_valid,
    output logic          tl_a_ready,

    output logic [2:0]    tl_d_opcode,
    output logic [1:0]    tl_d_param,
    output logic [3:0]    tl_d_size,
    output logic [RS-1:0] tl_d_source,
    output logic          tl_d_denied,
    output logic [31:0]   tl_d_data,
    output logic          tl_d_corrupt,
    output logic          tl_d_valid,
    input  logic          tl_d_ready
);

    localparam int W = DEPTH_LOG2;

    resp_state_e   state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [4:0]    last_q, last_d;
    logic [W-1:0]  base_q, base_d;
    logic [3:0]    size_q, size_d;
    logic [RS-1:0] source_q, source_d;
    logic [2:0]    opcode_q, opcode_d;
    logic          denied_q, denied_d;

    logic [W-1:0]  a_word;
    logic          a_aligned;
    logic          get_ok;
    logic          put_ok;
    logic          wr_en;
    logic [W-1:0]  rd_addr;
    logic [31:0]   rd_data;
    logic          unused_inputs;

    // High address bits above the array alias onto the same words
    assign a_word    = tl_a_address[W+1:2];
    assign a_aligned = is_aligned(tl_a_address, tl_a_size);
    assign get_ok    = (tl_a_opcode == TL_A_GET) && (tl_a_size <= TL_GET_MAX_SIZE) && a_aligned;
    assign put_ok    = ((tl_a_opcode == TL_A_PUT_FULL) || (tl_a_opcode == TL_A_PUT_PARTIAL))
                       && (tl_a_size <= TL_PUT_MAX_SIZE) && a_aligned;

    assign unused_inputs = ^{tl_a_param, tl_a_corrupt};

    tl_mem_array #(
        .ADDR_W (W)
    ) u_mem (
        .clk_i     (cpu_clock_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (a_word),
        .wr_be_i   (tl_a_mask),
        .wr_data_i (tl_a_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Response context and burst position registers
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            base_q   <= '0;
            size_q   <= '0;
            source_q <= '0;
            opcode_q <= TL_D_ACCESS_ACK;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            base_q   <= base_d;
            size_q   <= size_d;
            source_q <= source_d;
            opcode_q <= opcode_d;
            denied_q <= denied_d;
        end
    end

    // Request decode, burst sequencing and read-address steering
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        base_d     = base_q;
        size_d     = size_q;
        source_d   = source_q;
        opcode_d   = opcode_q;
        denied_d   = denied_q;
        tl_a_ready = 1'b0;
        tl_d_valid = 1'b0;
        wr_en      = 1'b0;
        // Re-read the presented word while stalled so the RAM output stays put
        rd_addr    = base_q + W'(cnt_q);

        case (state_q)
            ST_IDLE: begin
                tl_a_ready = 1'b1;
                rd_addr    = a_word;
                if (tl_a_valid) begin
                    size_d   = tl_a_size;
                    source_d = tl_a_source;
                    base_d   = a_word;
                    cnt_d    = '0;
                    last_d   = '0;
                    state_d  = ST_ACK;
                    denied_d = 1'b1;
                    opcode_d = TL_D_ACCESS_ACK;
                    if (tl_a_opcode == TL_A_GET) begin
                        opcode_d = TL_D_ACCESS_ACK_DATA;
                        if (get_ok) begin
                            state_d  = ST_READ;
                            denied_d = 1'b0;
                            last_d   = last_beat(tl_a_size);
                        end
                    end else if (put_ok) begin
                        wr_en    = 1'b1;
                        denied_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                tl_d_valid = 1'b1;
                if (tl_d_ready) begin
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        rd_addr = base_q + W'({1'b0, cnt_q} + 6'd1);
                    end
                end
            end
            ST_ACK: begin
                tl_d_valid = 1'b1;
                if (tl_d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tl_d_opcode  = opcode_q;
    assign tl_d_param   = 2'd0;
    assign tl_d_size    = size_q;
    assign tl_d_source  = source_q;
    assign tl_d_denied  = denied_q;
    assign tl_d_corrupt = 1'b0;
    // Only granted Get beats carry memory data; denied Gets and acks return zero
    assign tl_d_data    = (state_q == ST_READ) ? rd_data : 32'd0;

endmodule

// File: tb/tb_tl_mem_responder.sv
// tb/tb_tl_mem_responder.sv - scoreboard bench for tl_mem_responder with a transaction-level memory model
module tb_tl_mem_responder;

    localparam int DEPTH_LOG2 = 14;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int RS         = 1;

    logic          clk;
    logic          rst_n;
    logic [2:0]    a_opcode;
    logic [2:0]    a_param;
    logic [3:0]    a_size;
    logic [RS-1:0] a_source;
    logic [31:0]   a_address;
    logic [3:0]    a_mask;
    logic [31:0]   a_data;
    logic          a_corrupt;
    logic          a_valid;
    logic          a_ready;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [3:0]    d_size;
    logic [RS-1:0] d_source;
    logic          d_denied;
    logic [31:0]   d_data;
    logic          d_corrupt;
    logic          d_valid;
    logic          d_ready;

    tl_mem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RS         (RS)
    ) dut (
        .cpu_clock_i  (clk),
        .cpu_resetn_i (rst_n),
        .tl_a_opcode  (a_opcode),
        .tl_a_param   (a_param),
        .tl_a_size    (a_size),
        .tl_a_source  (a_source),
        .tl_a_address (a_address),
        .tl_a_mask    (a_mask),
        .tl_a_data    (a_data),
        .tl_a_corrupt (a_corrupt),
        .tl_a_valid   (a_valid),
        .tl_a_ready   (a_ready),
        .tl_d_opcode  (d_opcode),
        .tl_d_param   (d_param),
        .tl_d_size    (d_size),
        .tl_d_source  (d_source),
        .tl_d_denied  (d_denied),
        .tl_d_data    (d_data),
        .tl_d_corrupt (d_corrupt),
        .tl_d_valid   (d_valid),
        .tl_d_ready   (d_ready)
    );

    typedef struct packed {
        logic [2:0]    opcode;
        logic          denied;
        logic [3:0]    size;
        logic [RS-1:0] src;
        logic [31:0]   data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [int];
    int          checks     = 0;
    int          errors     = 0;
    int          beats_seen = 0;
    int          rdy_mode   = 0;
    exp_t        mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // D-ready pattern: 0 always ready, 1 alternate, 2 random
    initial begin
        d_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       d_ready = 1'b1;
                1:       d_ready = ~d_ready;
                default: d_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every presented beat must match the oldest outstanding expectation; pop only when consumed
    always @(negedge clk) begin
        if (rst_n && d_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL d_unexpected: got beat op=%0d data=%08h, expected no beat", d_opcode, d_data);
            end else begin
                mon_e = exp_q[0];
                if (d_opcode !== mon_e.opcode || d_denied !== mon_e.denied || d_size !== mon_e.size ||
                    d_source !== mon_e.src || d_data !== mon_e.data || d_param !== 2'd0 || d_corrupt !== 1'b0) begin
                    errors++;
                    $display("FAIL d_beat: got op=%0d den=%0b size=%0d src=%0d data=%08h param=%0d corrupt=%0b, expected op=%0d den=%0b size=%0d src=%0d data=%08h param=0 corrupt=0",
                             d_opcode, d_denied, d_size, d_source, d_data, d_param, d_corrupt,
                             mon_e.opcode, mon_e.denied, mon_e.size, mon_e.src, mon_e.data);
                end
                if (d_ready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    // Transaction-level memory: byte-addressed words aliased modulo the array size
    task automatic model_push(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] data, input logic [RS-1:0] src,
                              input bit force_en, input logic [31:0] force_data);
        longint unsigned blk;
        bit              aligned;
        int              idx;
        int              nbeats;
        logic [31:0]     w;
        exp_t            e;
        blk     = 64'd1 << size;
        aligned = ((64'(addr) % blk) == 0);
        idx     = int'((addr / 4) % DEPTH);
        e.size   = size;
        e.src    = src;
        e.data   = 32'd0;
        e.denied = 1'b1;
        if (op == 3'd4) begin
            e.opcode = 3'd1;
            if (size <= 7 && aligned) begin
                nbeats   = (size <= 2) ? 1 : (1 << size) / 4;
                e.denied = 1'b0;
                for (int i = 0; i < nbeats; i++) begin
                    e.data = force_en ? force_data : mem_m[(idx + i) % DEPTH];
                    exp_q.push_back(e);
                end
                return;
            end
        end else begin
            e.opcode = 3'd0;
            if ((op == 3'd0 || op == 3'd1) && size <= 2 && aligned) begin
                w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
                end
                mem_m[idx] = w;
                e.denied = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [RS-1:0] src,
                         input bit force_en, input logic [31:0] force_data);
        int waited;
        waited = 0;
        model_push(op, size, addr, mask, data, src, force_en, force_data);
        a_opcode  = op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = 1'($urandom_range(0, 1));
        a_valid   = 1'b1;
        while (!a_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!a_ready) begin
            checks++;
            errors++;
            $display("FAIL a_ready_timeout: got a_ready=0 for %0d cycles, expected 1", waited);
            a_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_data  = 32'($urandom);
        @(negedge clk);
        chk1("d_valid_after_accept", d_valid, 1'b1);
        chk1("a_ready_while_busy", a_ready, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int          target;
        int          n;
        int          r;
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] off;
        logic [31:0] lowm;

        rst_n     = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 4'd0;
        a_source  = '0;
        a_address = 32'd0;
        a_mask    = 4'd0;
        a_data    = 32'd0;
        a_corrupt = 1'b0;
        a_valid   = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk1("reset_d_valid", d_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_reset_a_ready", a_ready, 1'b1);
        chk1("post_reset_d_valid", d_valid, 1'b0);

        // Preload words 0..255 with random content
        rdy_mode = 0;
        for (int i = 0; i < 256; i++) begin
            issue(3'd0, 4'd2, 32'(i * 4), 4'hF, 32'($urandom), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end
        drain();

        // Write then read back a full word
        issue(3'd0, 4'd2, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
        issue(3'd4, 4'd2, 32'h100, 4'hF, 32'd0, 1'b1, 1'b1, 32'hDEADBEEF);
        drain();

        // Words at 0x80 hold their index, then full 32-beat burst with ready held high
        for (int i = 0; i < 32; i++) begin
            issue(3'd0, 4'd2, 32'h80 + 32'(i * 4), 4'hF, 32'(i), 1'b0, 1'b0, 32'd0);
        end
        issue(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0);
        drain();

        // Same burst with ready alternating every cycle
        rdy_mode = 1;
        issue(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0);
        drain();
        rdy_mode = 0;

        // Single byte merge into an existing word
        issue(3'd0, 4'd2, 32'h100, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'd0);
        issue(3'd1, 4'd0, 32'h101, 4'b0010, 32'h0000AB00, 1'b1, 1'b0, 32'd0);
        issue(3'd4, 4'd2, 32'h100, 4'hF, 32'd0, 1'b0, 1'b1, 32'h1122AB44);
        drain();

        // Denied requests leave memory untouched
        issue(3'd4, 4'd7, 32'h84, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0);
        issue(3'd2, 4'd2, 32'h80, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
        issue(3'd0, 4'd3, 32'h80, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
        issue(3'd4, 4'd8, 32'h0, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0);
        issue(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0);
        drain();

        // Randomised mix with random backpressure and aliased upper address bits
        rdy_mode = 2;
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                op = 3'd4;
                sz = 4'($urandom_range(0, 8));
            end else if (r < 8) begin
                op = (r < 6) ? 3'd0 : 3'd1;
                sz = 4'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 4))
                    0:       op = 3'd2;
                    1:       op = 3'd3;
                    2:       op = 3'd5;
                    3:       op = 3'd6;
                    default: op = 3'd7;
                endcase
                sz = 4'($urandom_range(0, 3));
            end
            off = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                lowm = (32'd1 << sz) - 32'd1;
                off  = off & ~lowm;
            end
            issue(op, sz, {16'($urandom), 6'd0, off[9:0]}, 4'($urandom), 32'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end
        drain();

        // Reset while beat 10 of a 32-beat burst is presented
        rdy_mode = 0;
        target = beats_seen + 10;
        issue(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0);
        n = 0;
        while (beats_seen < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (beats_seen < target) begin
            errors++;
            $display("FAIL burst_progress: got %0d beats, expected at least %0d", beats_seen, target);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk1("reset_mid_burst_d_valid", d_valid, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("after_abort_a_ready", a_ready, 1'b1);
        chk1("after_abort_d_valid", d_valid, 1'b0);
        issue(3'd4, 4'd7, 32'h80, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
